// File: rtl/spmc_pwm_deadtime_if.sv
// SpartanMC peripheral bus bundle for the dead-time stage.
// The MC drives address/data/strobes; the peripheral returns read data.
interface spmc_pwm_deadtime_if;
   logic [17:0] do_peri;
   logic [17:0] di_peri;
   logic [9:0]  addr_peri;
   logic        access_peri;
   logic        wr_peri;

   modport master (
      output do_peri,
      output addr_peri,
      output access_peri,
      output wr_peri,
      input  di_peri
   );

   modport slave (
      input  do_peri,
      input  addr_peri,
      input  access_peri,
      input  wr_peri,
      output di_peri
   );
endinterface

// File: rtl/spmc_pwm_deadtime.sv
// Complementary gate-drive stage with programmable dead time and
// sticky fault shutdown, configured through a 4-word register window.
module spmc_pwm_deadtime #(
   parameter logic [9:0] BASE_ADR = 10'h0,
   parameter int         DT_WIDTH = 8
) (
   input  logic                  clk_peri,
   input  logic                  reset,
   spmc_pwm_deadtime_if.slave    bus,
   input  logic                  pwm_in,
   input  logic                  fault,
   output logic                  out_h,
   output logic                  out_l
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOW_ON  = 3'd1,
      DT_L2H  = 3'd2,
      HIGH_ON = 3'd3,
      DT_H2L  = 3'd4
   } state_t;

   localparam logic [9:0]          BASE = BASE_ADR;
   localparam logic [DT_WIDTH-1:0] ONE  = DT_WIDTH'(1);

   state_t              state;
   state_t              state_nxt;
   logic [DT_WIDTH-1:0] cnt;
   logic [DT_WIDTH-1:0] cnt_nxt;
   logic [DT_WIDTH-1:0] dt_rise;
   logic [DT_WIDTH-1:0] dt_fall;
   logic [DT_WIDTH-1:0] rise_ld;
   logic [DT_WIDTH-1:0] fall_ld;
   logic                en;
   logic                pol;
   logic                sticky;
   logic                sel;
   logic                wr_en;
   logic                fclr;
   logic                halt;
   logic                unused_do;

   assign sel   = bus.access_peri && (bus.addr_peri[9:2] == BASE[9:2]);
   assign wr_en = sel && bus.wr_peri;
   assign fclr  = wr_en && (bus.addr_peri[1:0] == 2'd0) && bus.do_peri[2];
   assign halt  = fault || !en || sticky;

   assign unused_do = ^bus.do_peri;

   // A programmed dead time of zero still leaves one fully-off cycle
   assign rise_ld = (dt_rise == '0) ? ONE : dt_rise;
   assign fall_ld = (dt_fall == '0) ? ONE : dt_fall;

   always_ff @(posedge clk_peri or posedge reset) begin
      if (reset) begin
         en      <= 1'b0;
         pol     <= 1'b0;
         dt_rise <= '0;
         dt_fall <= '0;
      end else if (wr_en) begin
         case (bus.addr_peri[1:0])
            2'd0: begin
               en  <= bus.do_peri[0];
               pol <= bus.do_peri[1];
            end
            2'd1:    dt_rise <= bus.do_peri[DT_WIDTH-1:0];
            2'd2:    dt_fall <= bus.do_peri[DT_WIDTH-1:0];
            default: ;
         endcase
      end
   end

   // Fault outranks a simultaneous clear request
   always_ff @(posedge clk_peri or posedge reset) begin
      if (reset)
         sticky <= 1'b0;
      else if (fault)
         sticky <= 1'b1;
      else if (fclr)
         sticky <= 1'b0;
   end

   always_ff @(posedge clk_peri or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         out_h <= 1'b0;
         out_l <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         out_h <= (state_nxt == HIGH_ON) ^ pol;
         out_l <= (state_nxt == LOW_ON) ^ pol;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (halt) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (pwm_in) begin
                  cnt_nxt   = rise_ld;
                  state_nxt = DT_L2H;
               end else begin
                  cnt_nxt   = fall_ld;
                  state_nxt = DT_H2L;
               end
            end
            LOW_ON: begin
               if (pwm_in) begin
                  cnt_nxt   = rise_ld;
                  state_nxt = DT_L2H;
               end
            end
            DT_L2H: begin
               if (!pwm_in)
                  state_nxt = LOW_ON;
               else if (cnt <= ONE)
                  state_nxt = HIGH_ON;
               else
                  cnt_nxt = cnt - ONE;
            end
            HIGH_ON: begin
               if (!pwm_in) begin
                  cnt_nxt   = fall_ld;
                  state_nxt = DT_H2L;
               end
            end
            DT_H2L: begin
               if (pwm_in)
                  state_nxt = HIGH_ON;
               else if (cnt <= ONE)
                  state_nxt = LOW_ON;
               else
                  cnt_nxt = cnt - ONE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.di_peri = 18'h0;
      if (sel && !bus.wr_peri) begin
         case (bus.addr_peri[1:0])
            2'd0:    bus.di_peri = 18'({pol, en});
            2'd1:    bus.di_peri = 18'(dt_rise);
            2'd2:    bus.di_peri = 18'(dt_fall);
            default: bus.di_peri = 18'({pwm_in, sticky, state});
         endcase
      end
   end

endmodule

// File: tb/tb_spmc_pwm_deadtime.sv
// Directed bench for spmc_pwm_deadtime: timing, fault, polarity,
// dead-time scan over random pwm streams and async reset.
module tb_spmc_pwm_deadtime;

   localparam logic [9:0] BASE = 10'h40;

   logic clk_peri = 1'b0;
   logic reset    = 1'b1;
   logic pwm_in   = 1'b0;
   logic fault    = 1'b0;
   logic out_h;
   logic out_l;

   int nchk = 0;
   int nerr = 0;

   spmc_pwm_deadtime_if bus ();

   spmc_pwm_deadtime #(
      .BASE_ADR (BASE),
      .DT_WIDTH (8)
   ) dut (
      .clk_peri (clk_peri),
      .reset    (reset),
      .bus      (bus),
      .pwm_in   (pwm_in),
      .fault    (fault),
      .out_h    (out_h),
      .out_l    (out_l)
   );

   always #5 clk_peri = ~clk_peri;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_peri);
      #1;
   endtask

   task automatic wr_reg(input logic [9:0] a, input logic [17:0] d);
      bus.access_peri = 1'b1;
      bus.wr_peri     = 1'b1;
      bus.addr_peri   = a;
      bus.do_peri     = d;
      tick();
      bus.access_peri = 1'b0;
      bus.wr_peri     = 1'b0;
      bus.do_peri     = 18'h0;
   endtask

   task automatic rd_reg(input logic [9:0] a, output logic [17:0] d);
      bus.access_peri = 1'b1;
      bus.wr_peri     = 1'b0;
      bus.addr_peri   = a;
      #1;
      d = bus.di_peri;
      bus.access_peri = 1'b0;
   endtask

   logic [17:0] rd;
   int          gap;
   int          side;
   int          last_side;
   int          ovl;
   int          len;
   int          nseg;
   int          exp_gap;
   logic        lh;
   logic        ll;
   logic        lvl;
   int          dts [3];

   initial begin
      dts = '{0, 1, 255};
      bus.do_peri     = 18'h0;
      bus.addr_peri   = 10'h0;
      bus.access_peri = 1'b0;
      bus.wr_peri     = 1'b0;

      // reset state
      repeat (2) tick();
      check("rst_out", {out_h, out_l}, 2'b00);
      rd_reg(BASE + 10'd3, rd);
      check("rst_status", rd, 18'h0);
      reset = 1'b0;
      tick();

      // 1: power-up through the falling dead time
      wr_reg(BASE + 10'd1, 18'd3);
      wr_reg(BASE + 10'd2, 18'd2);
      wr_reg(BASE + 10'd0, 18'd1);
      rd_reg(BASE + 10'd1, rd);
      check("rd_dt_rise", rd, 18'd3);
      rd_reg(10'h0, rd);
      check("rd_other_base", rd, 18'h0);
      rd_reg(BASE + 10'd3, rd);
      check("t1_idle", rd, 18'h0);
      tick();
      rd_reg(BASE + 10'd3, rd);
      check("t1_dt_h2l", rd, 18'h4);
      check("t1_gap1", {out_h, out_l}, 2'b00);
      tick();
      check("t1_gap2", {out_h, out_l}, 2'b00);
      tick();
      check("t1_low_on", {out_h, out_l}, 2'b01);

      // 2: rising then falling transitions
      pwm_in = 1'b1;
      tick();
      check("t2_k", {out_h, out_l}, 2'b00);
      tick();
      tick();
      check("t2_k2", {out_h, out_l}, 2'b00);
      tick();
      check("t2_k3", {out_h, out_l}, 2'b10);
      pwm_in = 1'b0;
      tick();
      check("t2_m", {out_h, out_l}, 2'b00);
      tick();
      check("t2_m1", {out_h, out_l}, 2'b00);
      tick();
      check("t2_m2", {out_h, out_l}, 2'b01);

      // 3: pulse shorter than the rising dead time
      wr_reg(BASE + 10'd1, 18'd5);
      pwm_in = 1'b1;
      tick();
      check("t3_k", {out_h, out_l}, 2'b00);
      tick();
      pwm_in = 1'b0;
      check("t3_k1", {out_h, out_l}, 2'b00);
      tick();
      check("t3_back_low", {out_h, out_l}, 2'b01);

      // 4: fault shutdown and re-arm
      pwm_in = 1'b1;
      repeat (7) tick();
      check("t4_high_on", {out_h, out_l}, 2'b10);
      fault  = 1'b1;
      pwm_in = 1'b0;
      tick();
      fault = 1'b0;
      check("t4_fault_out", {out_h, out_l}, 2'b00);
      rd_reg(BASE + 10'd3, rd);
      check("t4_status", rd, 18'h8);
      repeat (4) tick();
      check("t4_hold_out", {out_h, out_l}, 2'b00);
      fault = 1'b1;
      wr_reg(BASE + 10'd0, 18'h5);
      fault = 1'b0;
      rd_reg(BASE + 10'd3, rd);
      check("t4_fclr_vs_fault", rd, 18'h8);
      rd_reg(BASE + 10'd0, rd);
      check("t4_ctrl_rd", rd, 18'h1);
      wr_reg(BASE + 10'd0, 18'h5);
      rd_reg(BASE + 10'd3, rd);
      check("t4_cleared", rd, 18'h0);
      tick();
      rd_reg(BASE + 10'd3, rd);
      check("t4_rearm", rd, 18'h4);
      tick();
      check("t4_rearm_gap", {out_h, out_l}, 2'b00);
      tick();
      check("t4_rearm_low", {out_h, out_l}, 2'b01);

      // 5: polarity inversion, then dead-time scan
      wr_reg(BASE + 10'd0, 18'h3);
      tick();
      check("t5_pol", {out_h, out_l}, 2'b10);
      for (int i = 0; i < 3; i++) begin
         pwm_in = 1'b0;
         wr_reg(BASE + 10'd1, 18'(dts[i]));
         wr_reg(BASE + 10'd2, 18'(dts[i]));
         repeat (260) tick();
         check($sformatf("t5_settle_dt%0d", dts[i]), {out_h, out_l}, 2'b10);
         exp_gap   = (dts[i] == 0) ? 1 : dts[i];
         gap       = 0;
         last_side = 0;
         ovl       = 0;
         lvl       = 1'b0;
         nseg      = (dts[i] == 255) ? 4 : 8;
         for (int s = 0; s < nseg; s++) begin
            lvl    = ~lvl;
            pwm_in = lvl;
            len    = $urandom_range(exp_gap + 3, exp_gap + 14);
            repeat (len) begin
               tick();
               lh = ~out_h;
               ll = ~out_l;
               if (lh && ll)
                  ovl++;
               if (!lh && !ll) begin
                  gap++;
               end else begin
                  side = lh ? 1 : 0;
                  if (side != last_side)
                     check($sformatf("t5_gap_dt%0d", dts[i]), gap, exp_gap);
                  gap       = 0;
                  last_side = side;
               end
            end
         end
         check($sformatf("t5_overlap_dt%0d", dts[i]), ovl, 0);
      end

      // 6: async reset in the middle of a rising dead time
      wr_reg(BASE + 10'd1, 18'd5);
      pwm_in = 1'b1;
      tick();
      check("t6_in_dt", {out_h, out_l}, 2'b11);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_out", {out_h, out_l}, 2'b00);
      pwm_in = 1'b0;
      for (int r = 0; r < 4; r++) begin
         rd_reg(BASE + 10'(r), rd);
         check($sformatf("t6_reg%0d", r), rd, 18'h0);
      end
      tick();
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
